// File: rtl/psg_pkg.sv
// rtl/psg_pkg.sv - shared constants for the multi-channel PSG
package psg_pkg;

    localparam logic [2:0] WAVE_OFF   = 3'd0;
    localparam logic [2:0] WAVE_TRI   = 3'd1;
    localparam logic [2:0] WAVE_SAW   = 3'd2;
    localparam logic [2:0] WAVE_PULSE = 3'd3;
    localparam logic [2:0] WAVE_NOISE = 3'd4;

    localparam logic [1:0] REG_FREQ_LO = 2'd0;
    localparam logic [1:0] REG_FREQ_HI = 2'd1;
    localparam logic [1:0] REG_DUTY    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam logic [14:0] LFSR_SEED = 15'h0001;

endpackage

// File: rtl/psg_channel.sv
// rtl/psg_channel.sv - one tone channel: registers, divider, phase, noise, envelope, scaling
module psg_channel
    import psg_pkg::*;
#(
    parameter int FREQ_W   = 12,
    parameter int SAMPLE_W = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [1:0]          reg_sel,
    input  logic [7:0]          wdata,
    input  logic                frame_tick,
    output logic [SAMPLE_W-1:0] scaled
);

    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic [7:0]          duty_q, duty_d;
    logic [2:0]          wave_q, wave_d;
    logic                env_en_q, env_en_d;
    logic [3:0]          vol_q, vol_d;
    logic [FREQ_W-1:0]   count_q, count_d;
    logic [SAMPLE_W-1:0] phase_q, phase_d;
    logic [14:0]         lfsr_q, lfsr_d;
    logic [3:0]          level_q, level_d;

    logic                tick;
    logic                ctrl_wr;
    logic [SAMPLE_W-1:0] tri_base;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W+3:0] product;

    // Register writes; reg1 only carries the freq bits above the low byte
    always_comb begin
        freq_d   = freq_q;
        duty_d   = duty_q;
        wave_d   = wave_q;
        env_en_d = env_en_q;
        vol_d    = vol_q;
        if (wr_en) begin
            case (reg_sel)
                REG_FREQ_LO: freq_d[7:0]        = wdata;
                REG_FREQ_HI: freq_d[FREQ_W-1:8] = wdata[FREQ_W-9:0];
                REG_DUTY:    duty_d             = wdata;
                REG_CTRL: begin
                    wave_d   = wdata[2:0];
                    env_en_d = wdata[3];
                    vol_d    = wdata[7:4];
                end
                default: ;
            endcase
        end
    end

    // Divider, phase, noise LFSR and envelope level; >= compare means a lowered freq ticks at once
    always_comb begin
        ctrl_wr = wr_en && (reg_sel == REG_CTRL);
        tick    = (count_q >= freq_q);
        count_d = tick ? '0 : count_q + FREQ_W'(1);
        phase_d = tick ? phase_q + SAMPLE_W'(1) : phase_q;
        lfsr_d  = tick ? {lfsr_q[1] ^ lfsr_q[0], lfsr_q[14:1]} : lfsr_q;
        if (ctrl_wr) begin
            level_d = wdata[7:4];
        end else if (!env_en_q) begin
            level_d = vol_q;
        end else if (frame_tick && (level_q != 4'd0)) begin
            level_d = level_q - 4'd1;
        end else begin
            level_d = level_q;
        end
    end

    // Waveform generation from phase/LFSR and volume scaling
    always_comb begin
        tri_base = {phase_q[SAMPLE_W-2:0], 1'b0};
        case (wave_q)
            WAVE_TRI:   sample = phase_q[SAMPLE_W-1] ? ~tri_base : tri_base;
            WAVE_SAW:   sample = phase_q;
            WAVE_PULSE: sample = (phase_q[SAMPLE_W-1 -: 8] < duty_q) ? '1 : '0;
            WAVE_NOISE: sample = lfsr_q[14 -: SAMPLE_W];
            default:    sample = '0;
        endcase
        product = (SAMPLE_W+4)'(sample) * (SAMPLE_W+4)'(level_q);
        scaled  = product[SAMPLE_W+3:4];
    end

    // Channel state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freq_q   <= '0;
            duty_q   <= '0;
            wave_q   <= WAVE_OFF;
            env_en_q <= 1'b0;
            vol_q    <= '0;
            count_q  <= '0;
            phase_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            level_q  <= '0;
        end else begin
            freq_q   <= freq_d;
            duty_q   <= duty_d;
            wave_q   <= wave_d;
            env_en_q <= env_en_d;
            vol_q    <= vol_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            lfsr_q   <= lfsr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/psg_multi.sv
// rtl/psg_multi.sv - NUM_CH-channel PSG with shared register bus, mixer and delta-sigma DAC
module psg_multi
    import psg_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          FREQ_W    = 12,
    parameter int          SAMPLE_W  = 10,
    parameter logic [15:0] FRAME_DIV = 16'd50000,
    parameter int          MIX_W     = SAMPLE_W + $clog2(NUM_CH) + 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(NUM_CH)+1:0]   address,
    input  logic [7:0]                  data,
    input  logic                        wr,
    output logic [MIX_W-1:0]            mix_sample,
    output logic                        audio
);

    localparam int ADDR_W = $clog2(NUM_CH) + 2;

    logic [NUM_CH-1:0]   wr_ch;
    logic [SAMPLE_W-1:0] scaled [NUM_CH];

    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                frame_tick;
    logic [MIX_W-1:0]    mix_q, mix_d;
    logic [MIX_W-1:0]    acc_q, acc_d;
    logic [MIX_W:0]      acc_sum;
    logic                audio_q, audio_d;

    // Channel select from the upper address bits
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ch[i] = wr && ((address >> 2) == ADDR_W'(i));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            psg_channel #(
                .FREQ_W   (FREQ_W),
                .SAMPLE_W (SAMPLE_W)
            ) u_ch (
                .clk        (clk),
                .reset_n    (reset_n),
                .wr_en      (wr_ch[g]),
                .reg_sel    (address[1:0]),
                .wdata      (data),
                .frame_tick (frame_tick),
                .scaled     (scaled[g])
            );
        end
    endgenerate

    // Frame counter, mix sum and first-order delta-sigma next state
    always_comb begin
        frame_tick  = (frame_cnt_q == FRAME_DIV - 16'd1);
        frame_cnt_d = frame_tick ? 16'd0 : frame_cnt_q + 16'd1;
        mix_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_d = mix_d + MIX_W'(scaled[i]);
        end
        acc_sum = {1'b0, acc_q} + {1'b0, mix_q};
        acc_d   = acc_sum[MIX_W-1:0];
        audio_d = acc_sum[MIX_W];
    end

    // Shared state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            mix_q       <= '0;
            acc_q       <= '0;
            audio_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            mix_q       <= mix_d;
            acc_q       <= acc_d;
            audio_q     <= audio_d;
        end
    end

    assign mix_sample = mix_q;
    assign audio      = audio_q;

endmodule

// File: tb/tb_psg_multi.sv
// tb/tb_psg_multi.sv - directed vector bench for psg_multi
module tb_psg_multi;

    localparam int MIX_W = 13;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       address;
    logic [7:0]       data;
    logic             wr;
    logic [MIX_W-1:0] mix_sample;
    logic             audio;

    int n_vec = 0;
    int n_err = 0;
    int last_edge = -1;
    int ones;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic       w;
        int         exp_mix;
    } vec_t;

    vec_t vecs [25];
    int   exp_a [25] = '{0,0,0,0,0,1,1,1,1,2,2,2,2,3,3,4,5,6,7,7,7,7,8,8,9};

    always #5 clk = ~clk;

    psg_multi #(
        .NUM_CH    (4),
        .FREQ_W    (12),
        .SAMPLE_W  (10),
        .FRAME_DIV (16'd4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .data       (data),
        .wr         (wr),
        .mix_sample (mix_sample),
        .audio      (audio)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [7:0] d, input logic w);
        address = a;
        data    = d;
        wr      = w;
        @(posedge clk);
        #1;
        last_edge++;
        address = '0;
        data    = '0;
        wr      = 1'b0;
    endtask

    task automatic idle_until(input int k);
        while (last_edge < k) step(4'd0, 8'd0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wr      = 1'b0;
        address = '0;
        data    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        last_edge = -1;
    endtask

    initial begin
        reset_n = 1'b0;
        address = '0;
        data    = '0;
        wr      = 1'b0;

        // Divider table: ch0 sawtooth vol 15, freq 3 -> 0 -> 7 -> 1 (written at count 3)
        for (int i = 0; i < 25; i++) vecs[i] = '{4'd0, 8'd0, 1'b0, exp_a[i]};
        vecs[0]  = '{4'd0, 8'd3,    1'b1, exp_a[0]};
        vecs[1]  = '{4'd3, 8'hF2,   1'b1, exp_a[1]};
        vecs[13] = '{4'd0, 8'd0,    1'b1, exp_a[13]};
        vecs[17] = '{4'd0, 8'd7,    1'b1, exp_a[17]};
        vecs[20] = '{4'd0, 8'd1,    1'b1, exp_a[20]};

        do_reset();
        check("reset_mix", int'(mix_sample), 0);
        check("reset_audio", int'(audio), 0);
        for (int i = 0; i < 25; i++) begin
            step(vecs[i].a, vecs[i].d, vecs[i].w);
            check($sformatf("div_vec%0d", i), int'(mix_sample), vecs[i].exp_mix);
        end

        // Triangle around the midpoint and the wrap, freq 0 so phase == edge index
        do_reset();
        step(4'd3, 8'hF1, 1'b1);
        idle_until(510);  check("tri_510", int'(mix_sample), 956);
        idle_until(511);  check("tri_511", int'(mix_sample), 958);
        idle_until(512);  check("tri_512", int'(mix_sample), 959);
        idle_until(1023); check("tri_1023", int'(mix_sample), 0);
        idle_until(1024); check("tri_wrap0", int'(mix_sample), 0);
        idle_until(1025); check("tri_wrap1", int'(mix_sample), 1);
        idle_until(1026); check("tri_wrap2", int'(mix_sample), 3);

        // Pulse: duty 128 threshold, then duty 0 silent, then duty 255
        do_reset();
        step(4'd2, 8'd128, 1'b1);
        step(4'd3, 8'hF3, 1'b1);
        idle_until(2);    check("pulse_low_phase", int'(mix_sample), 959);
        idle_until(511);  check("pulse_msb127", int'(mix_sample), 959);
        idle_until(512);  check("pulse_msb128", int'(mix_sample), 0);
        idle_until(999);
        step(4'd2, 8'd0, 1'b1);
        idle_until(1030); check("pulse_duty0", int'(mix_sample), 0);
        idle_until(1039);
        step(4'd2, 8'd255, 1'b1);
        idle_until(1044); check("pulse_duty255_lo", int'(mix_sample), 959);
        idle_until(2043); check("pulse_duty255_254", int'(mix_sample), 959);
        idle_until(2044); check("pulse_duty255_255", int'(mix_sample), 0);

        // Envelope decay with frame ticks on edges 3,7,11,...; reload on a tick edge
        do_reset();
        step(4'd1, 8'h0F, 1'b1);
        step(4'd2, 8'd255, 1'b1);
        step(4'd3, 8'hFB, 1'b1);
        idle_until(3);   check("env_l15", int'(mix_sample), 959);
        idle_until(4);   check("env_l14", int'(mix_sample), 895);
        idle_until(8);   check("env_l13", int'(mix_sample), 831);
        idle_until(59);  check("env_l1", int'(mix_sample), 63);
        idle_until(60);  check("env_l0", int'(mix_sample), 0);
        idle_until(100); check("env_hold0", int'(mix_sample), 0);
        idle_until(102);
        step(4'd3, 8'hFB, 1'b1);
        idle_until(104); check("env_reload", int'(mix_sample), 959);
        idle_until(107); check("env_reload_hold", int'(mix_sample), 959);
        idle_until(108); check("env_reload_dec", int'(mix_sample), 895);

        // Four sawtooth channels in lockstep reaching phase 1023
        do_reset();
        for (int c = 0; c < 4; c++) step(4'(4 * c + 3), 8'hF2, 1'b1);
        idle_until(1022); check("mix4_1022", int'(mix_sample), 3832);
        idle_until(1023); check("mix4_1023", int'(mix_sample), 3836);
        idle_until(1024); check("mix4_wrap", int'(mix_sample), 0);

        // Constant mix via slow pulses; ones count over 2^MIX_W cycles
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(4'(4 * c + 0), 8'hFF, 1'b1);
            step(4'(4 * c + 1), 8'h0F, 1'b1);
            step(4'(4 * c + 2), 8'hFF, 1'b1);
        end
        step(4'd3,  8'hF3, 1'b1);
        step(4'd7,  8'h83, 1'b1);
        step(4'd11, 8'h00, 1'b1);
        step(4'd15, 8'h13, 1'b1);
        idle_until(20);
        check("dac_mix", int'(mix_sample), 1533);
        ones = 0;
        for (int i = 0; i < (1 << MIX_W); i++) begin
            step(4'd0, 8'd0, 1'b0);
            ones += int'(audio);
        end
        check("dac_ones", ones, 1533);

        // Asynchronous reset mid-run, then noise from the seed
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_mix", int'(mix_sample), 0);
        check("async_rst_audio", int'(audio), 0);
        do_reset();
        step(4'd3, 8'hF4, 1'b1);
        check("off_after_reset", int'(mix_sample), 0);
        idle_until(1);  check("noise_s1", int'(mix_sample), 480);
        idle_until(2);  check("noise_s2", int'(mix_sample), 240);
        idle_until(3);  check("noise_s3", int'(mix_sample), 120);
        idle_until(14); check("noise_s14", int'(mix_sample), 0);
        idle_until(15); check("noise_s15", int'(mix_sample), 480);
        idle_until(16); check("noise_s16", int'(mix_sample), 720);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
